// File: rtl/des_pkg.sv
// Shared DES widths, the round-engine state encoding and the DES round function f(R, K):
// expansion E, key mixing, S-box substitution and P permutation.
package des_pkg;

    localparam int DES_BLK_W    = 64;
    localparam int DES_HALF_W   = 32;
    localparam int DES_SUBKEY_W = 48;
    localparam int DES_ROUNDS   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } des_state_e;

    // Bit positions are numbered 1..32 from the MSB, as in the DES tables.
    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    // Entry 4*box+row holds one S-box row; column c is the nibble at [63-4c -: 4].
    localparam logic [63:0] SBOX [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    function automatic logic [DES_HALF_W-1:0] des_f(input logic [DES_HALF_W-1:0] r,
                                                     input logic [DES_SUBKEY_W-1:0] k);
        logic [DES_SUBKEY_W-1:0] x;
        logic [DES_HALF_W-1:0]   s_out;
        logic [DES_HALF_W-1:0]   p_out;
        logic [5:0]              six;
        logic [63:0]             row_w;
        x     = '0;
        s_out = '0;
        p_out = '0;
        for (int i = 0; i < 48; i++) begin
            x[47-i] = r[32-E_TAB[i]];
        end
        x = x ^ k;
        for (int s = 0; s < 8; s++) begin
            six   = x[47-6*s -: 6];
            row_w = SBOX[4*s + int'({six[5], six[0]})];
            s_out[31-4*s -: 4] = row_w[63-4*int'(six[4:1]) -: 4];
        end
        for (int i = 0; i < 32; i++) begin
            p_out[31-i] = s_out[32-P_TAB[i]];
        end
        return p_out;
    endfunction

endpackage

// File: rtl/des_feistel.sv
// DES round function with a configurable latency: the result for (r, k) is valid LAT-1
// cycles after they are applied, so a register sampling it lands LAT clock edges later.
module des_feistel
    import des_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic                    clk,
    input  logic [DES_HALF_W-1:0]   r,
    input  logic [DES_SUBKEY_W-1:0] k,
    output logic [DES_HALF_W-1:0]   result
);

    logic [DES_HALF_W-1:0] f_p0;

    assign f_p0 = des_f(r, k);

    if (LAT == 1) begin : g_comb
        logic unused_clk;
        assign unused_clk = clk;
        assign result     = f_p0;
    end else begin : g_pipe
        logic [DES_HALF_W-1:0] f_p [LAT-1];

        // Stage boundary: f_p[i] holds the f result computed i+1 cycles ago.
        always_ff @(posedge clk) begin
            f_p[0] <= f_p0;
            for (int i = 1; i < LAT-1; i++) begin
                f_p[i] <= f_p[i-1];
            end
        end

        assign result = f_p[LAT-2];
    end

endmodule

// File: rtl/des_round_iter.sv
// Iterative DES Feistel round engine: runs ROUNDS rounds on one post-IP block through a
// single shared des_feistel, requesting subkeys by index in encrypt or decrypt order.
module des_round_iter
    import des_pkg::*;
#(
    parameter int ROUNDS     = DES_ROUNDS,
    parameter int F_LAT      = 1,
    parameter bit FINAL_SWAP = 1'b1,
    parameter int IDX_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DES_BLK_W-1:0]    in_data,
    input  logic                    in_decrypt,
    input  logic                    flush,
    output logic [IDX_W-1:0]        key_idx,
    input  logic [DES_SUBKEY_W-1:0] subkey,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DES_BLK_W-1:0]    out_data,
    output logic                    busy
);

    localparam int               FW      = (F_LAT > 1) ? $clog2(F_LAT) : 1;
    localparam logic [FW-1:0]    F_LAST  = FW'(F_LAT - 1);
    localparam logic [FW-1:0]    F_ONE   = FW'(1);
    localparam logic [IDX_W-1:0] R_LAST  = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    des_state_e             state_q, state_d;
    logic [DES_HALF_W-1:0]  l_q, l_d, r_q, r_d, new_r, f_out;
    logic                   mode_q, mode_d;
    logic [IDX_W-1:0]       rnd_q, rnd_d, key_q, key_d;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [DES_BLK_W-1:0]   out_data_q, out_data_d;
    logic                   busy_q, busy_d;

    des_feistel #(
        .LAT    (F_LAT)
    ) u_feistel (
        .clk    (clk),
        .r      (r_q),
        .k      (subkey),
        .result (f_out)
    );

    assign new_r = l_q ^ f_out;

    always_comb begin
        state_d     = state_q;
        l_d         = l_q;
        r_d         = r_q;
        mode_d      = mode_q;
        rnd_d       = rnd_q;
        fcnt_d      = fcnt_q;
        key_d       = key_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q && !flush) begin
                    l_d        = in_data[DES_BLK_W-1:DES_HALF_W];
                    r_d        = in_data[DES_HALF_W-1:0];
                    mode_d     = in_decrypt;
                    rnd_d      = '0;
                    fcnt_d     = '0;
                    key_d      = in_decrypt ? R_LAST : '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end else if (fcnt_q == F_LAST) begin
                    l_d    = r_q;
                    r_d    = new_r;
                    fcnt_d = '0;
                    if (rnd_q == R_LAST) begin
                        // key_idx is left on the last round's index so it never leaves range.
                        rnd_d       = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = FINAL_SWAP ? {new_r, r_q} : {r_q, new_r};
                        state_d     = DONE;
                    end else begin
                        rnd_d = rnd_q + IDX_ONE;
                        key_d = mode_q ? (key_q - IDX_ONE) : (key_q + IDX_ONE);
                    end
                end else begin
                    fcnt_d = fcnt_q + F_ONE;
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Stage boundary: all engine state and outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            mode_q      <= 1'b0;
            rnd_q       <= '0;
            fcnt_q      <= '0;
            key_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            l_q         <= l_d;
            r_q         <= r_d;
            mode_q      <= mode_d;
            rnd_q       <= rnd_d;
            fcnt_q      <= fcnt_d;
            key_q       <= key_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign key_idx   = key_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_des_round_iter.sv
// Bench for des_round_iter: known-answer DES vectors with key 133457799BBCDFF1 and
// handshake, flush and reset corner cases on three parameterisations.
module tb_des_round_iter;

    localparam logic [63:0] V0 = 64'hCC00CCFFF0AAF0AA;
    localparam logic [63:0] E0 = 64'h0A4CD99543423234;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [47:0] ks(input logic [3:0] idx);
        case (idx)
            4'd0:  return 48'h1B02EFFC7072;
            4'd1:  return 48'h79AED9DBC9E5;
            4'd2:  return 48'h55FC8A42CF99;
            4'd3:  return 48'h72ADD6DB351D;
            4'd4:  return 48'h7CEC07EB53A8;
            4'd5:  return 48'h63A53E507B2F;
            4'd6:  return 48'hEC84B7F618BC;
            4'd7:  return 48'hF78A3AC13BFB;
            4'd8:  return 48'hE0DBEBEDE781;
            4'd9:  return 48'hB1F347BA464F;
            4'd10: return 48'h215FD3DED386;
            4'd11: return 48'h7571F59467E9;
            4'd12: return 48'h97C5D1FABA41;
            4'd13: return 48'h5F43B7F2E73A;
            4'd14: return 48'hBF918D3D3F0A;
            default: return 48'hCB3D8B0E17F5;
        endcase
    endfunction

    // Main engine: ROUNDS=16, F_LAT=1, FINAL_SWAP=1
    logic        in_valid, in_ready, in_decrypt, flush, out_valid, out_ready, busy;
    logic [63:0] in_data, out_data;
    logic [3:0]  key_idx;
    logic [47:0] subkey;
    assign subkey = ks(key_idx);

    des_round_iter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_decrypt(in_decrypt), .flush(flush), .key_idx(key_idx), .subkey(subkey),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    // Slow engine: F_LAT=3
    logic        s3_in_valid, s3_in_ready, s3_out_valid, s3_busy;
    logic [63:0] s3_in_data, s3_out_data;
    logic [3:0]  s3_key_idx;
    logic [47:0] s3_subkey;
    assign s3_subkey = ks(s3_key_idx);

    des_round_iter #(.F_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(s3_in_valid), .in_ready(s3_in_ready),
        .in_data(s3_in_data), .in_decrypt(1'b0), .flush(1'b0), .key_idx(s3_key_idx),
        .subkey(s3_subkey), .out_valid(s3_out_valid), .out_ready(1'b1),
        .out_data(s3_out_data), .busy(s3_busy)
    );

    // Single-round engine without the final swap
    logic        r1_in_valid, r1_in_ready, r1_out_valid, r1_busy;
    logic [63:0] r1_in_data, r1_out_data;
    logic [3:0]  r1_key_idx;
    logic [47:0] r1_subkey;
    assign r1_subkey = ks(r1_key_idx);

    des_round_iter #(.ROUNDS(1), .FINAL_SWAP(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(r1_in_valid), .in_ready(r1_in_ready),
        .in_data(r1_in_data), .in_decrypt(1'b0), .flush(1'b0), .key_idx(r1_key_idx),
        .subkey(r1_subkey), .out_valid(r1_out_valid), .out_ready(1'b1),
        .out_data(r1_out_data), .busy(r1_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every completed output handshake pops the oldest expected block.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h with no block pending", out_data);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic dec, input logic [63:0] exp,
                        output int acc);
        int n;
        n = 0;
        in_data    = d;
        in_decrypt = dec;
        in_valid   = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready %b after %0d cycles, required 1", in_ready, n);
        end else begin
            exp_q.push_back(exp);
        end
        tick();
        acc        = cyc;
        in_valid   = 1'b0;
        in_decrypt = 1'($urandom_range(0, 1));
        in_data    = {$urandom, $urandom};
    endtask

    task automatic wait_out(input logic dec, output int lat);
        int bad;
        bad = 0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            if (lat < 16 && key_idx !== (dec ? 4'(15 - lat) : 4'(lat))) bad++;
            tick();
            lat++;
        end
        check("key_seq_errors", bad, 0);
    endtask

    typedef struct {
        logic [63:0] din;
        logic        dec;
        logic [3:0]  key0;
        logic [63:0] dout;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int acc, acc2, lat, bad, n;
        vecs[0] = '{din: V0, dec: 1'b0, key0: 4'd0,  dout: E0};
        vecs[1] = '{din: E0, dec: 1'b1, key0: 4'd15, dout: V0};
        vecs[2] = '{din: V0, dec: 1'b0, key0: 4'd0,  dout: E0};

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_decrypt = 1'b0; flush = 1'b0; out_ready = 1'b1;
        s3_in_valid = 1'b0; s3_in_data = '0; r1_in_valid = 1'b0; r1_in_data = '0;
        repeat (3) tick();
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_key_idx", key_idx, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        check("in_ready_after_reset", in_ready, 1);

        for (int i = 0; i < 3; i++) begin
            send(vecs[i].din, vecs[i].dec, vecs[i].dout, acc);
            check("first_key_idx", key_idx, vecs[i].key0);
            check("busy_in_run", busy, 1);
            wait_out(vecs[i].dec, lat);
            check("latency", lat, 16);
            tick();
        end

        // Back-to-back blocks with out_ready high
        send(V0, 1'b0, E0, acc);
        send(E0, 1'b1, V0, acc2);
        check("throughput_period", acc2 - acc, 18);
        wait_out(1'b1, lat);
        tick();

        // Backpressure on the result
        out_ready = 1'b0;
        send(V0, 1'b0, E0, acc);
        wait_out(1'b0, lat);
        bad = 0;
        repeat (5) begin
            tick();
            check("stall_out_data", out_data, E0);
            if (in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        check("stall_handshake_errors", bad, 0);
        out_ready = 1'b1;
        tick();
        check("in_ready_after_release", in_ready, 1);
        check("out_valid_after_release", out_valid, 0);

        // Flush at round 7
        send(V0, 1'b0, E0, acc);
        repeat (7) tick();
        check("flush_round_key", key_idx, 7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        check("flush_in_ready", in_ready, 1);
        check("flush_out_valid", out_valid, 0);
        check("flush_busy", busy, 0);
        bad = 0;
        repeat (25) begin
            tick();
            if (out_valid) bad++;
        end
        check("flush_no_output", bad, 0);
        send(V0, 1'b0, E0, acc);
        wait_out(1'b0, lat);
        check("after_flush_latency", lat, 16);
        tick();

        // Flush while a result waits in DONE
        out_ready = 1'b0;
        send(E0, 1'b1, V0, acc);
        wait_out(1'b1, lat);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        check("flush_done_out_valid", out_valid, 0);
        check("flush_done_in_ready", in_ready, 1);

        // Flush in IDLE blocks the accept
        in_data = V0; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("idle_flush_busy", busy, 0);
        check("idle_flush_in_ready", in_ready, 1);

        // Asynchronous reset at round 7
        send(E0, 1'b1, V0, acc);
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("async_rst_in_ready", in_ready, 0);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_key_idx", key_idx, 0);
        check("async_rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_release_in_ready", in_ready, 1);
        bad = 0;
        repeat (20) begin
            tick();
            if (out_valid) bad++;
        end
        check("rst_no_output", bad, 0);
        send(V0, 1'b0, E0, acc);
        wait_out(1'b0, lat);
        check("after_rst_latency", lat, 16);
        tick();

        // F_LAT = 3
        s3_in_data = V0; s3_in_valid = 1'b1;
        n = 0;
        while (!s3_in_ready && n < 50) begin tick(); n++; end
        tick();
        s3_in_valid = 1'b0;
        lat = 0; bad = 0;
        while (!s3_out_valid && lat < 200) begin
            if (s3_key_idx !== 4'(lat / 3)) bad++;
            tick();
            lat++;
        end
        check("flat3_key_seq_errors", bad, 0);
        check("flat3_latency", lat, 48);
        check("flat3_out_data", s3_out_data, E0);

        // ROUNDS = 1, FINAL_SWAP = 0
        r1_in_data = V0; r1_in_valid = 1'b1;
        n = 0;
        while (!r1_in_ready && n < 50) begin tick(); n++; end
        tick();
        r1_in_valid = 1'b0;
        check("r1_key_idx", r1_key_idx, 0);
        lat = 0;
        while (!r1_out_valid && lat < 50) begin tick(); lat++; end
        check("r1_latency", lat, 1);
        check("r1_out_data", r1_out_data, 64'hF0AAF0AAEF4A6544);

        repeat (3) tick();
        check("pending_blocks", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/des_round_iter.md
Name: des_round_iter

Overview:
- Iterative, handshaked DES Feistel round engine. Runs ROUNDS Feistel rounds on one 64-bit block (post-IP L||R) through a single shared des_feistel instance.
- Sits between the IP stage and the IP^-1 stage of the DES datapath, and replaces a chain of unrolled round instances when area matters.
- Requests subkeys by round index from the external key schedule. Supports encrypt and decrypt order.

Parameters:
- ROUNDS, 16: number of Feistel rounds per block. Legal range 1..16.
- F_LAT, 1: clock latency of des_feistel, from R/K applied to result valid. Must be ≥1.
- FINAL_SWAP, 1: 1 = output {R,L} after the last round (standard DES preoutput). 0 = output {L,R} unswapped.
- IDX_W, 4: width of key_idx. Must satisfy 2^IDX_W ≥ ROUNDS.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine can accept a block.
- in_data  in  64  block, [63:32]=L0, [31:0]=R0.
- in_decrypt  in  1  sampled with in_data; 1 = reverse subkey order.
- flush  in  1  synchronous abort of the current block.
- key_idx  out  IDX_W  subkey index requested for the current round.
- subkey  in  48  subkey for key_idx. Combinational from key_idx, stable for the whole round.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  64  result block.
- busy  out  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. All state and outputs are registered.
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_data=0, key_idx=0, busy=0, round counter=0, F-wait counter=0, L/R=0, mode=0.
  - in_ready rises in the first clock after reset release.
  - Reset asserted mid-operation discards the block; no output is produced.

IDLE:
- in_ready=1.
- On in_valid&in_ready, capture in_data into L/R and in_decrypt into mode, then go to RUN. in_ready drops the next cycle.
- key_idx = 0 for encrypt, ROUNDS-1 for decrypt, presented in the first RUN cycle.

RUN:
- Each round lasts exactly F_LAT cycles.
- L/R and key_idx are held stable for the whole round; des_feistel sees R and subkey.
- On the last cycle of the round, when F-wait reaches F_LAT-1:
  - L <= R, R <= L ^ F_out.
  - round counter increments.
  - key_idx steps +1 (encrypt) or -1 (decrypt).
- After round ROUNDS-1 completes, go to DONE.
  - out_data = {R,L} if FINAL_SWAP=1, else {L,R}, using the post-round values.
  - out_valid=1.

DONE:
- out_valid and out_data are held unchanged until out_valid&out_ready.
- On that handshake: out_valid=0, go to IDLE, in_ready=1 the same next cycle.
- No input is accepted in the DONE cycle, even when out_ready is high.

Latency and throughput:
- Latency from the accept edge to out_valid high is ROUNDS*F_LAT cycles.
- Throughput is one block per ROUNDS*F_LAT+2 cycles with out_ready tied high.

flush:
- flush in RUN or DONE returns to IDLE next cycle, with out_valid=0 and in_ready=1. Block data is dropped.
- flush in IDLE blocks acceptance in that cycle.
- flush has priority over all handshakes.

Other rules:
- No width growth in the datapath: XOR is 32-bit only. The round counter wraps only via the state transition.
- key_idx never leaves 0..ROUNDS-1.
- in_decrypt is ignored outside the accept cycle.

Decomposition:
- des_pkg holds:
  - DES_BLK_W=64, DES_HALF_W=32, DES_SUBKEY_W=48.
  - The state enum (IDLE/RUN/DONE).
  - Default round count DES_ROUNDS=16.
- Sub-module: the existing des_feistel (clk, R, K, result). Its latency must equal F_LAT.
- The key schedule stays outside this block.

Test Plan:
1. Encrypt with F_LAT=1, bench key schedule for key 133457799BBCDFF1. in_data=CC00CCFFF0AAF0AA (IP of 0123456789ABCDEF).
   - After round 1, internal L/R must be F0AAF0AA/EF4A6544 with key_idx=0 and subkey=1B02EFFC7072.
   - out_data must be 0A4CD99543423234, with out_valid rising exactly 16 cycles after accept.
2. Decrypt round trip: in_data=0A4CD99543423234, in_decrypt=1.
   - key_idx sequence must be 15..0.
   - out_data must be CC00CCFFF0AAF0AA.
3. Backpressure: hold out_ready=0 for 5 cycles after out_valid.
   - out_data must stay stable and in_ready must stay 0.
   - Release out_ready: in_ready must be 1 on the next cycle.
4. Flush and reset mid-operation:
   - Assert flush at round 7: out_valid must never rise, in_ready=1 next cycle. The next block (vector 1) must still produce 0A4CD99543423234.
   - Repeat with rst_n low at round 7: all outputs must be at reset values asynchronously.
5. F_LAT=3 with ROUNDS=16:
   - key_idx must change every 3 cycles.
   - Latency must be 48 cycles, with the same output as vector 1.
6. ROUNDS=1, FINAL_SWAP=0: in_data=CC00CCFFF0AAF0AA with subkey 1B02EFFC7072 -> out_data=F0AAF0AAEF4A6544.
